// File: rtl/exec_unit_pipe_pkg.sv
// rtl/exec_unit_pipe_pkg.sv - op codes, flag indices and FSM states shared by exec_unit_pipe
package exec_pkg;

   // ALU codes occupy op[3:0]; op[4] selects the multiplier
   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_BIC = 4'hE;
   localparam logic [3:0] OP_MVN = 4'hF;
   localparam logic [4:0] OP_MUL = 5'h10;

   localparam int N_IDX = 3;
   localparam int Z_IDX = 2;
   localparam int C_IDX = 1;
   localparam int V_IDX = 0;

   typedef enum logic {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/exec_unit_pipe_if.sv
// rtl/exec_unit_pipe_if.sv - operation/result handshake bundle for exec_unit_pipe
interface exec_unit_pipe_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [4:0]   op;
   logic         set_flags;
   logic [W-1:0] opr1;
   logic [W-1:0] opr2;
   logic         dep_sel;
   logic [W-1:0] dep_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         is_write;
   logic [3:0]   nzcv;
   logic         illegal;

   modport master (
      output in_valid, op, set_flags, opr1, opr2, dep_sel, dep_data, out_ready,
      input  in_ready, out_valid, result, is_write, nzcv, illegal
   );

   modport slave (
      input  in_valid, op, set_flags, opr1, opr2, dep_sel, dep_data, out_ready,
      output in_ready, out_valid, result, is_write, nzcv, illegal
   );
endinterface

// File: rtl/exec_unit_pipe_alu.sv
// rtl/exec_unit_pipe_alu.sv - combinational W-bit ALU with NZCV generation
module exec_alu_comb
   import exec_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [3:0]   i_op,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_c,
   output logic [W-1:0] o_result,
   output logic         o_write,
   output logic         o_n,
   output logic         o_z,
   output logic         o_c,
   output logic         o_v,
   output logic         o_c_upd
);
   logic [W-1:0] w_x;
   logic [W-1:0] w_y;
   logic         w_ci;
   logic [W:0]   w_sum;

   // Every arithmetic op is one adder: x + y + ci, subtracts invert the subtrahend
   always_comb begin
      w_x  = i_a;
      w_y  = i_b;
      w_ci = 1'b0;
      case (i_op)
         OP_SUB, OP_CMP: begin
            w_y  = ~i_b;
            w_ci = 1'b1;
         end
         OP_RSB: begin
            w_x  = i_b;
            w_y  = ~i_a;
            w_ci = 1'b1;
         end
         OP_ADC: w_ci = i_c;
         OP_SBC: begin
            w_y  = ~i_b;
            w_ci = i_c;
         end
         OP_RSC: begin
            w_x  = i_b;
            w_y  = ~i_a;
            w_ci = i_c;
         end
         default: ;
      endcase
   end

   assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{W{1'b0}}, w_ci};

   always_comb begin
      o_result = w_sum[W-1:0];
      o_write  = 1'b1;
      o_c_upd  = 1'b1;
      case (i_op)
         OP_AND, OP_TST: begin
            o_result = i_a & i_b;
            o_c_upd  = 1'b0;
         end
         OP_EOR, OP_TEQ: begin
            o_result = i_a ^ i_b;
            o_c_upd  = 1'b0;
         end
         OP_ORR: begin
            o_result = i_a | i_b;
            o_c_upd  = 1'b0;
         end
         OP_MOV: begin
            o_result = i_b;
            o_c_upd  = 1'b0;
         end
         OP_BIC: begin
            o_result = i_a & ~i_b;
            o_c_upd  = 1'b0;
         end
         OP_MVN: begin
            o_result = ~i_b;
            o_c_upd  = 1'b0;
         end
         default: ;
      endcase
      if (i_op == OP_TST || i_op == OP_TEQ || i_op == OP_CMP || i_op == OP_CMN)
         o_write = 1'b0;
   end

   assign o_n = o_result[W-1];
   assign o_z = (o_result == '0);
   assign o_c = w_sum[W];
   assign o_v = (w_x[W-1] == w_y[W-1]) && (w_sum[W-1] != w_x[W-1]);

endmodule

// File: rtl/exec_unit_pipe.sv
// rtl/exec_unit_pipe.sv - execute stage: ALU, NZCV register, iterative multiplier, valid/ready handshakes
module exec_unit_pipe
   import exec_pkg::*;
#(
   parameter int  W      = 32,
   parameter bit  MUL_EN = 1'b1,
   localparam int CNT_W  = $clog2(W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   exec_unit_pipe_if.slave  bus
);
   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_out_valid;
   logic [W-1:0]     r_result;
   logic             r_is_write;
   logic             r_illegal;
   logic [3:0]       r_nzcv;
   logic [W-1:0]     r_mcand;
   logic [W-1:0]     r_mplier;
   logic [W-1:0]     r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_mul_setf;

   logic [W-1:0]     w_opr2;
   logic             w_is_mul;
   logic             w_out_free;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_mul_start;
   logic             w_alu_take;
   logic             w_mul_last;
   logic             w_mul_done;
   logic [W-1:0]     w_acc_nxt;
   logic [3:0]       w_nzcv_alu;
   logic [3:0]       w_nzcv_mul;
   logic [W-1:0]     w_alu_result;
   logic             w_alu_write;
   logic             w_alu_n;
   logic             w_alu_z;
   logic             w_alu_c;
   logic             w_alu_v;
   logic             w_alu_c_upd;

   assign w_opr2      = bus.dep_sel ? bus.dep_data : bus.opr2;
   assign w_is_mul    = bus.op[4];
   assign w_out_free  = !r_out_valid || bus.out_ready;
   assign w_in_ready  = (r_state == IDLE) && w_out_free;
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_mul_start = w_accept && w_is_mul && MUL_EN;
   // Illegal MULs take the single-cycle ALU response path
   assign w_alu_take  = w_accept && !w_mul_start;
   assign w_mul_last  = (r_state == MUL_BUSY) && (r_cnt == CNT_W'(W - 1));
   assign w_mul_done  = w_mul_last && w_out_free;
   assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);

   exec_alu_comb #(.W(W)) u_alu (
      .i_op     (bus.op[3:0]),
      .i_a      (bus.opr1),
      .i_b      (w_opr2),
      .i_c      (r_nzcv[C_IDX]),
      .o_result (w_alu_result),
      .o_write  (w_alu_write),
      .o_n      (w_alu_n),
      .o_z      (w_alu_z),
      .o_c      (w_alu_c),
      .o_v      (w_alu_v),
      .o_c_upd  (w_alu_c_upd)
   );

   always_comb begin
      w_nzcv_alu = r_nzcv;
      w_nzcv_mul = r_nzcv;
      if (bus.set_flags) begin
         w_nzcv_alu[N_IDX] = w_alu_n;
         w_nzcv_alu[Z_IDX] = w_alu_z;
         if (w_alu_c_upd) begin
            w_nzcv_alu[C_IDX] = w_alu_c;
            w_nzcv_alu[V_IDX] = w_alu_v;
         end
      end
      if (r_mul_setf) begin
         w_nzcv_mul[N_IDX] = w_acc_nxt[W-1];
         w_nzcv_mul[Z_IDX] = (w_acc_nxt == '0);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (w_mul_start) w_state_nxt = MUL_BUSY;
         MUL_BUSY: if (w_mul_done)  w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_is_write  <= 1'b0;
         r_illegal   <= 1'b0;
         r_nzcv      <= 4'h0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_mul_setf  <= 1'b0;
      end else begin
         if (w_alu_take) begin
            r_out_valid <= 1'b1;
            if (w_is_mul) begin
               r_result   <= '0;
               r_is_write <= 1'b0;
               r_illegal  <= 1'b1;
            end else begin
               r_result   <= w_alu_result;
               r_is_write <= w_alu_write;
               r_illegal  <= 1'b0;
               r_nzcv     <= w_nzcv_alu;
            end
         end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_acc_nxt;
            r_is_write  <= 1'b1;
            r_illegal   <= 1'b0;
            r_nzcv      <= w_nzcv_mul;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
         end

         // The final step is folded into w_acc_nxt at completion, so the counter parks at W-1
         if (w_mul_start) begin
            r_mcand    <= bus.opr1;
            r_mplier   <= w_opr2;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_mul_setf <= bus.set_flags;
         end else if ((r_state == MUL_BUSY) && !w_mul_last) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.is_write  = r_is_write;
   assign bus.nzcv      = r_nzcv;
   assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_exec_unit_pipe.sv
// tb/tb_exec_unit_pipe.sv - self-checking bench for exec_unit_pipe with a reference model and scoreboard
module tb_exec_unit_pipe;
   import exec_pkg::*;

   localparam int W = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   exec_unit_pipe_if #(.W(W)) bus ();
   exec_unit_pipe_if #(.W(W)) bus_nm ();

   exec_unit_pipe #(.W(W), .MUL_EN(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exec_unit_pipe #(.W(W), .MUL_EN(1'b0)) dut_nm (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_nm)
   );

   typedef struct {
      logic [W-1:0] res;
      bit           wr;
      logic [3:0]   nz;
      int           acc_cyc;
      int           lat;
      bit           seen;
   } exp_t;

   exp_t       q[$];
   logic [3:0] m_nzcv = 4'h0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference: true-integer arithmetic, carry/borrow and signed-range overflow
   function automatic void model_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [3:0] f_in, input bit sf,
                                    output logic [W-1:0] res, output bit wr, output logic [3:0] f_out);
      longint ua, ub, sa, sb, full, sfull, cin;
      bit arith, add_type;
      logic [63:0] prod;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      cin = longint'(f_in[C_IDX]);
      arith = 1'b1; add_type = 1'b1; wr = 1'b1; full = 0; sfull = 0; res = '0;
      f_out = f_in;
      if (op[4]) begin
         prod  = 64'(a) * 64'(b);
         res   = prod[W-1:0];
         arith = 1'b0;
      end else begin
         case (op[3:0])
            OP_AND, OP_TST: begin res = a & b;  arith = 1'b0; end
            OP_EOR, OP_TEQ: begin res = a ^ b;  arith = 1'b0; end
            OP_ORR:         begin res = a | b;  arith = 1'b0; end
            OP_MOV:         begin res = b;      arith = 1'b0; end
            OP_BIC:         begin res = a & ~b; arith = 1'b0; end
            OP_MVN:         begin res = ~b;     arith = 1'b0; end
            OP_SUB, OP_CMP: begin full = ua - ub; sfull = sa - sb; add_type = 1'b0; end
            OP_RSB:         begin full = ub - ua; sfull = sb - sa; add_type = 1'b0; end
            OP_ADD, OP_CMN: begin full = ua + ub; sfull = sa + sb; end
            OP_ADC:         begin full = ua + ub + cin; sfull = sa + sb + cin; end
            OP_SBC:         begin full = ua - ub - (1 - cin); sfull = sa - sb - (1 - cin); add_type = 1'b0; end
            default:        begin full = ub - ua - (1 - cin); sfull = sb - sa - (1 - cin); add_type = 1'b0; end
         endcase
         if (op[3:0] == OP_TST || op[3:0] == OP_TEQ || op[3:0] == OP_CMP || op[3:0] == OP_CMN) wr = 1'b0;
      end
      if (arith) res = full[W-1:0];
      if (sf) begin
         f_out[N_IDX] = res[W-1];
         f_out[Z_IDX] = (res == '0);
         if (arith) begin
            f_out[C_IDX] = add_type ? full[32] : (full >= 0);
            f_out[V_IDX] = (sfull > longint'(32'h7FFF_FFFF)) || (sfull < -longint'(32'h8000_0000));
         end
      end
   endfunction

   // Scoreboard: every cycle with out_valid is checked against the head of the model queue
   initial begin
      logic [W-1:0] r;
      bit           w;
      logic [3:0]   f;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            m_nzcv = 4'h0;
         end else begin
            if (bus.out_valid) begin
               if (q.size() == 0) begin
                  chk("spurious out_valid", 64'(bus.out_valid), 64'd0);
               end else begin
                  if (!q[0].seen) begin
                     chk("sb latency", 64'(cyc - q[0].acc_cyc - 1), 64'(q[0].lat));
                     q[0].seen = 1'b1;
                  end
                  chk("sb result", 64'(bus.result), 64'(q[0].res));
                  chk("sb is_write", 64'(bus.is_write), 64'(q[0].wr));
                  chk("sb illegal", 64'(bus.illegal), 64'd0);
                  chk("sb nzcv", 64'(bus.nzcv), 64'(q[0].nz));
                  if (bus.out_ready) void'(q.pop_front());
               end
            end else if (q.size() > 0 && cyc > q[0].acc_cyc + 1 + q[0].lat) begin
               chk("sb result timeout", 64'(bus.out_valid), 64'd1);
               void'(q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
               exp_t e;
               model_op(bus.op, bus.opr1, bus.dep_sel ? bus.dep_data : bus.opr2, m_nzcv, bus.set_flags, r, w, f);
               m_nzcv    = f;
               e.res     = r;
               e.wr      = w;
               e.nz      = f;
               e.acc_cyc = cyc;
               e.lat     = bus.op[4] ? W : 0;
               e.seen    = 1'b0;
               q.push_back(e);
            end
         end
      end
   end

   task automatic do_op(input logic [4:0] op, input bit sf, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit dsel, input logic [W-1:0] dd, input bit keep);
      bit got = 1'b0;
      bus.op = op; bus.set_flags = sf; bus.opr1 = a; bus.opr2 = b;
      bus.dep_sel = dsel; bus.dep_data = dd; bus.in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin got = 1'b1; break; end
      end
      chk("accept", 64'(got), 64'd1);
      @(posedge clk); #1;
      if (!keep) bus.in_valid = 1'b0;
   endtask

   task automatic check_out(input string name, input logic [W-1:0] res, input bit wr, input logic [3:0] nz);
      chk({name, " out_valid"}, 64'(bus.out_valid), 64'd1);
      chk({name, " result"}, 64'(bus.result), 64'(res));
      chk({name, " is_write"}, 64'(bus.is_write), 64'(wr));
      chk({name, " nzcv"}, 64'(bus.nzcv), 64'(nz));
   endtask

   task automatic wait_out();
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (bus.out_valid) break;
      end
   endtask

   logic [W-1:0] ta[3] = '{32'h1234_5678, 32'h8000_0000, 32'h0000_0000};
   logic [W-1:0] tb[3] = '{32'h0F0F_0F0F, 32'h8000_0000, 32'hFFFF_FFFF};
   logic [4:0]   mix_op[6] = '{5'h10, 5'h04, 5'h10, 5'h07, 5'h03, 5'h0B};
   logic [W-1:0] mix_a[6]  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0003, 32'h0000_0005, 32'h0000_0001, 32'hFFFF_FFFF};
   logic [W-1:0] mix_b[6]  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h0000_0005, 32'h0000_0002, 32'h0000_0001};
   bit           mix_done;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] mr;
      bit           mw;
      logic [3:0]   mf;
      int           bad_rdy, early;

      bus.in_valid = 0; bus.op = 0; bus.set_flags = 0; bus.opr1 = 0; bus.opr2 = 0;
      bus.dep_sel = 0; bus.dep_data = 0; bus.out_ready = 1;
      bus_nm.in_valid = 0; bus_nm.op = 0; bus_nm.set_flags = 0; bus_nm.opr1 = 0; bus_nm.opr2 = 0;
      bus_nm.dep_sel = 0; bus_nm.dep_data = 0; bus_nm.out_ready = 1;

      // Model pins
      model_op({1'b0, OP_ADD}, 32'h7FFF_FFFF, 32'h1, 4'h0, 1'b1, mr, mw, mf);
      chk("model ADD ovf result", 64'(mr), 64'h8000_0000);
      chk("model ADD ovf nzcv", 64'(mf), 64'h9);
      model_op({1'b0, OP_SUB}, 32'd5, 32'd5, 4'h0, 1'b1, mr, mw, mf);
      chk("model SUB eq nzcv", 64'(mf), 64'h6);
      model_op({1'b0, OP_RSC}, 32'd3, 32'd10, 4'h0, 1'b1, mr, mw, mf);
      chk("model RSC result", 64'(mr), 64'd6);
      chk("model RSC nzcv", 64'(mf), 64'h2);
      model_op({1'b0, OP_CMN}, 32'h8000_0000, 32'h8000_0000, 4'h0, 1'b1, mr, mw, mf);
      chk("model CMN nzcv", 64'(mf), 64'h7);
      chk("model CMN write", 64'(mw), 64'd0);
      model_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h0, 1'b0, mr, mw, mf);
      chk("model MUL wrap", 64'(mr), 64'd1);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst result", 64'(bus.result), 64'd0);
      chk("rst is_write", 64'(bus.is_write), 64'd0);
      chk("rst nzcv", 64'(bus.nzcv), 64'd0);
      chk("rst illegal", 64'(bus.illegal), 64'd0);
      chk("rst in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op({1'b0, OP_ADD}, 1, 32'h7FFF_FFFF, 32'h1, 0, 0, 0);
      check_out("ADD ovf", 32'h8000_0000, 1, 4'b1001);
      do_op({1'b0, OP_ADC}, 1, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);
      check_out("ADC c0", 32'hFFFF_FFFF, 1, 4'b1000);

      // Reset during a multiply abandons it
      do_op(OP_MUL, 1, 32'd3, 32'd4, 0, 0, 0);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("mulrst out_valid", 64'(bus.out_valid), 64'd0);
      chk("mulrst nzcv", 64'(bus.nzcv), 64'd0);
      chk("mulrst in_ready", 64'(bus.in_ready), 64'd1);
      early = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         if (bus.out_valid) early++;
      end
      chk("mulrst no result", 64'(early), 64'd0);
      @(posedge clk); #1;

      do_op({1'b0, OP_ADD}, 1, 32'hFFFF_FFFF, 32'h1, 0, 0, 0);
      check_out("ADD wrap", 32'h0, 1, 4'b0110);
      do_op({1'b0, OP_CMP}, 1, 32'd5, 32'd5, 0, 0, 1);
      check_out("CMP eq", 32'h0, 0, 4'b0110);
      do_op({1'b0, OP_SBC}, 1, 32'd10, 32'd3, 0, 0, 0);
      check_out("SBC c1", 32'd7, 1, 4'b0010);
      do_op({1'b0, OP_MOV}, 0, 32'h0, 32'h11, 1, 32'h22, 0);
      check_out("MOV dep", 32'h22, 1, 4'b0010);
      do_op({1'b0, OP_MVN}, 1, 32'h0, 32'h0, 0, 0, 0);
      check_out("MVN 0", 32'hFFFF_FFFF, 1, 4'b1010);

      // MUL latency and in_ready hold-off
      do_op(OP_MUL, 1, 32'h0001_0000, 32'h0001_0003, 0, 0, 0);
      bad_rdy = 0; early = 0;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         if (bus.in_ready) bad_rdy++;
         if (bus.out_valid) early++;
      end
      chk("MUL in_ready low cycles", 64'(bad_rdy), 64'd0);
      chk("MUL early out_valid", 64'(early), 64'd0);
      @(negedge clk);
      check_out("MUL", 32'h0003_0000, 1, 4'b0010);
      @(posedge clk); #1;

      do_op(OP_MUL, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
      wait_out();
      check_out("MUL wrap", 32'h1, 1, 4'b0010);
      @(posedge clk); #1;

      // Output stall with back-to-back offers
      bus.out_ready = 1'b0;
      do_op({1'b0, OP_ADD}, 0, 32'd1, 32'd2, 0, 0, 1);
      bus.op = {1'b0, OP_EOR}; bus.opr1 = 32'hF0; bus.opr2 = 32'hFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall in_ready", 64'(bus.in_ready), 64'd0);
         chk("stall result", 64'(bus.result), 64'd3);
         chk("stall out_valid", 64'(bus.out_valid), 64'd1);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      do_op({1'b0, OP_EOR}, 0, 32'hF0, 32'hFF, 0, 0, 1);
      check_out("after stall EOR", 32'h0F, 1, 4'b0010);
      do_op({1'b0, OP_SUB}, 0, 32'd9, 32'd4, 0, 0, 0);
      check_out("after stall SUB", 32'd5, 1, 4'b0010);

      // All ALU codes, back to back, against the model
      for (int p = 0; p < 3; p++)
         for (int o = 0; o < 16; o++)
            do_op({1'b0, 4'(o)}, 1, ta[p], tb[p], 0, 0, 1);
      bus.in_valid = 1'b0;

      // Mixed stream with a toggling downstream
      mix_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 6; k++)
               do_op(mix_op[k], k[0], mix_a[k], mix_b[k], k[1], mix_b[k] ^ 32'h5A, 1);
            bus.in_valid = 1'b0;
            mix_done = 1'b1;
         end
         begin
            while (!mix_done) begin
               @(posedge clk); #1;
               bus.out_ready = ((cyc % 3) != 0);
            end
         end
      join
      bus.out_ready = 1'b1;
      repeat (W + 6) @(posedge clk);
      #1;
      chk("scoreboard drained", 64'(q.size()), 64'd0);

      // MUL_EN=0 build
      bus_nm.op = {1'b0, OP_SUB}; bus_nm.set_flags = 1; bus_nm.opr1 = 32'd3; bus_nm.opr2 = 32'd5;
      bus_nm.in_valid = 1;
      @(negedge clk);
      chk("nm in_ready", 64'(bus_nm.in_ready), 64'd1);
      @(posedge clk); #1;
      chk("nm SUB result", 64'(bus_nm.result), 64'hFFFF_FFFE);
      chk("nm SUB nzcv", 64'(bus_nm.nzcv), 64'b1000);
      bus_nm.op = OP_MUL;
      @(negedge clk);
      chk("nm MUL in_ready", 64'(bus_nm.in_ready), 64'd1);
      @(posedge clk); #1;
      bus_nm.in_valid = 0;
      chk("nm MUL out_valid", 64'(bus_nm.out_valid), 64'd1);
      chk("nm MUL illegal", 64'(bus_nm.illegal), 64'd1);
      chk("nm MUL is_write", 64'(bus_nm.is_write), 64'd0);
      chk("nm MUL result", 64'(bus_nm.result), 64'd0);
      chk("nm MUL nzcv", 64'(bus_nm.nzcv), 64'b1000);
      @(posedge clk); #1;
      chk("nm illegal pulse end", 64'(bus_nm.illegal), 64'd0);
      chk("nm out_valid end", 64'(bus_nm.out_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
